// File: rtl/multi_cycle_cpu.sv
// multi_cycle_cpu: MIPS-subset core with a FETCH/DECODE/EXEC/MEM/WB FSM over req/ready memories.
module multi_cycle_cpu #(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              inst_req_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_ready_i,
  input  logic [31:0]       inst_rdata_i,
  output logic              data_req_o,
  output logic [3:0]        data_wen_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [31:0]       data_wdata_o,
  input  logic              data_ready_i,
  input  logic [31:0]       data_rdata_i,
  output logic [31:0]       pc_o,
  output logic [2:0]        state_o,
  output logic              rf_we_o,
  output logic [4:0]        rf_waddr_o,
  output logic [31:0]       rf_wdata_o,
  output logic              retire_o,
  output logic              trap_o
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd7} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, imm_q, imm_d, alu_q, alu_d, mdr_q, mdr_d;
  logic [31:0] rf_q [32];
  logic [31:0] alu_r, opb, pc4;
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, sh;
  logic        is_r, legal, is_lw, is_sw, is_br, is_j, is_jal, zext, wr_slot;
  assign op     = ir_q[31:26];
  assign fn     = ir_q[5:0];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign sh     = ir_q[10:6];
  assign is_r   = op == 6'h00;
  assign is_lw  = op == 6'h23;
  assign is_sw  = op == 6'h2b;
  assign is_br  = op == 6'h04 || op == 6'h05;
  assign is_j   = op == 6'h02;
  assign is_jal = op == 6'h03;
  assign zext   = op inside {6'h0c, 6'h0d, 6'h0e};
  assign legal  = is_r ? fn inside {6'h00, 6'h02, 6'h03, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b}
                       : op inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b};
  assign pc4    = pc_q + 32'd4;
  assign opb    = is_r ? b_q : imm_q;
  always_comb begin
    alu_r = '0;
    if (is_r)
      case (fn)
        6'h00:   alu_r = b_q << sh;
        6'h02:   alu_r = b_q >> sh;
        6'h03:   alu_r = $signed(b_q) >>> sh;
        6'h23:   alu_r = a_q - b_q;
        6'h24:   alu_r = a_q & b_q;
        6'h25:   alu_r = a_q | b_q;
        6'h26:   alu_r = a_q ^ b_q;
        6'h27:   alu_r = ~(a_q | b_q);
        6'h2a:   alu_r = {31'd0, $signed(a_q) < $signed(b_q)};
        6'h2b:   alu_r = {31'd0, a_q < b_q};
        default: alu_r = a_q + b_q;
      endcase
    else
      case (op)
        6'h0a:   alu_r = {31'd0, $signed(a_q) < $signed(opb)};
        6'h0c:   alu_r = a_q & opb;
        6'h0d:   alu_r = a_q | opb;
        6'h0e:   alu_r = a_q ^ opb;
        6'h0f:   alu_r = {ir_q[15:0], 16'd0};
        default: alu_r = a_q + opb;
      endcase
  end
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    imm_d      = imm_q;
    alu_d      = alu_q;
    mdr_d      = mdr_q;
    inst_req_o = 1'b0;
    data_req_o = 1'b0;
    retire_o   = 1'b0;
    case (state_q)
      FETCH: begin
        inst_req_o = 1'b1;
        ir_d       = inst_ready_i ? inst_rdata_i : ir_q;
        state_d    = inst_ready_i ? DECODE : FETCH;
      end
      DECODE: begin
        a_d     = rf_q[rs];
        b_d     = rf_q[rt];
        imm_d   = zext ? {16'd0, ir_q[15:0]} : {{16{ir_q[15]}}, ir_q[15:0]};
        state_d = legal ? EXEC : TRAP;
      end
      EXEC: begin
        alu_d = alu_r;
        if (is_lw || is_sw) state_d = alu_r[1:0] != 2'b00 ? TRAP : MEM;
        else if (is_br || is_j || is_jal) begin
          pc_d     = is_br ? (((a_q == b_q) ^ (op == 6'h05)) ? pc4 + (imm_q << 2) : pc4)
                           : {pc4[31:28], ir_q[25:0], 2'b00};
          retire_o = 1'b1;
          state_d  = FETCH;
        end
        else state_d = WB;
      end
      MEM: begin
        data_req_o = 1'b1;
        if (data_ready_i) begin
          mdr_d    = data_rdata_i;
          pc_d     = is_sw ? pc4 : pc_q;
          retire_o = is_sw;
          state_d  = is_sw ? FETCH : WB;
        end
      end
      WB: begin
        pc_d     = pc4;
        retire_o = 1'b1;
        state_d  = FETCH;
      end
      default: state_d = TRAP;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
    end
  end
  // $0 is never written, so reading rf_q[0] always yields zero
  assign wr_slot    = state_q == WB || (state_q == EXEC && is_jal);
  assign rf_waddr_o = is_jal ? 5'd31 : is_r ? rd : rt;
  assign rf_we_o    = wr_slot && rf_waddr_o != 5'd0;
  assign rf_wdata_o = is_jal ? pc4 : is_lw ? mdr_q : alu_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    else if (rf_we_o) rf_q[rf_waddr_o] <= rf_wdata_o;
  end
  assign inst_addr_o  = pc_q[ADDR_W-1:0];
  assign data_addr_o  = alu_q[ADDR_W-1:0];
  assign data_wen_o   = data_req_o ? {4{is_sw}} : 4'b0000;
  assign data_wdata_o = b_q;
  assign pc_o         = pc_q;
  assign state_o      = state_q;
  assign trap_o       = state_q == TRAP;
endmodule

// File: tb/tb_multi_cycle_cpu.sv
// tb_multi_cycle_cpu: directed program run with hand-computed expectations and wait-state memories.
module tb_multi_cycle_cpu;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        inst_req, inst_ready, data_req, data_ready, rf_we, retire, trap;
  logic [11:0] inst_addr, data_addr;
  logic [31:0] inst_rdata, data_wdata, data_rdata, pc, rf_wdata;
  logic [3:0]  data_wen;
  logic [2:0]  state;
  logic [4:0]  rf_waddr;
  logic [31:0] imem [1024];
  logic [31:0] dmem [1024];
  logic        inst_en = 1'b1;
  int          dwait = 0, dcnt = 0;
  int          vectors = 0, errs = 0;
  int          r_cyc, r_dcyc;
  logic        r_we, r_stable, r_seen, seen_req;
  logic [4:0]  r_wa;
  logic [31:0] r_wd, r_npc, r_dwd;
  logic [3:0]  r_wen;
  logic [11:0] r_daddr;

  multi_cycle_cpu dut (
    .clk(clk), .rst_n(rst_n),
    .inst_req_o(inst_req), .inst_addr_o(inst_addr), .inst_ready_i(inst_ready), .inst_rdata_i(inst_rdata),
    .data_req_o(data_req), .data_wen_o(data_wen), .data_addr_o(data_addr), .data_wdata_o(data_wdata),
    .data_ready_i(data_ready), .data_rdata_i(data_rdata),
    .pc_o(pc), .state_o(state), .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .retire_o(retire), .trap_o(trap)
  );

  always #5 clk = ~clk;
  assign inst_ready = inst_en;
  assign inst_rdata = imem[inst_addr[11:2]];
  assign data_ready = data_req && dcnt == dwait;
  assign data_rdata = dmem[data_addr[11:2]];
  always @(posedge clk) begin
    dcnt <= (data_req && !data_ready) ? dcnt + 1 : 0;
    if (data_req && data_ready && data_wen == 4'hF) dmem[data_addr[11:2]] <= data_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one instruction from its FETCH cycle through its retire cycle, recording bus activity.
  task automatic exec();
    r_cyc = 1; r_dcyc = 0; r_stable = 1'b1; r_seen = 1'b0;
    r_wen = '0; r_daddr = '0; r_dwd = '0;
    forever begin
      if (data_req) begin
        if (!r_seen) begin
          r_seen = 1'b1; r_wen = data_wen; r_daddr = data_addr; r_dwd = data_wdata;
        end else if (data_wen !== r_wen || data_addr !== r_daddr || data_wdata !== r_dwd) r_stable = 1'b0;
        r_dcyc++;
      end
      if (retire === 1'b1 || r_cyc >= 40) break;
      tick();
      r_cyc++;
    end
    r_we = rf_we; r_wa = rf_waddr; r_wd = rf_wdata;
    tick();
    r_npc = pc;
  endtask

  task automatic alu_step(input string tag, input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] npc);
    exec();
    chk({tag, "_cyc"}, r_cyc, 4);
    chk({tag, "_we"}, {31'd0, r_we}, 1);
    chk({tag, "_wa"}, {27'd0, r_wa}, {27'd0, wa});
    chk({tag, "_wd"}, r_wd, wd);
    chk({tag, "_npc"}, r_npc, npc);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      imem[i] = 32'hFC00_0000;
      dmem[i] = 32'h0;
    end
    imem[0]  = 32'h2401_0005; // ADDIU $1,$0,5
    imem[1]  = 32'h2402_FFFD; // ADDIU $2,$0,-3
    imem[2]  = 32'h0022_1821; // ADDU  $3,$1,$2
    imem[3]  = 32'hAC03_0008; // SW    $3,8($0)
    imem[4]  = 32'h8C04_0008; // LW    $4,8($0)
    imem[5]  = 32'h1021_0002; // BEQ   $1,$1,+2
    imem[8]  = 32'h1421_0002; // BNE   $1,$1,+2
    imem[9]  = 32'h0C00_0040; // JAL   0x40
    imem[64] = 32'h2400_0007; // ADDIU $0,$0,7
    imem[65] = 32'h0000_2821; // ADDU  $5,$0,$0
    imem[66] = 32'h03E0_3021; // ADDU  $6,$31,$0
    imem[67] = 32'h0041_3823; // SUBU  $7,$2,$1
    imem[68] = 32'h0041_402A; // SLT   $8,$2,$1
    imem[69] = 32'h0041_482B; // SLTU  $9,$2,$1
    imem[70] = 32'h0002_5043; // SRA   $10,$2,1
    imem[71] = 32'h0002_5F02; // SRL   $11,$2,28
    imem[72] = 32'h304C_FFF0; // ANDI  $12,$2,0xFFF0
    imem[73] = 32'h3C0D_1234; // LUI   $13,0x1234
    imem[74] = 32'h8C0E_0002; // LW    $14,2($0)
    repeat (2) tick();
    chk("rst_inst_req", {31'd0, inst_req}, 1);
    chk("rst_inst_addr", {20'd0, inst_addr}, 0);
    chk("rst_pc", pc, 0);
    chk("rst_state", {29'd0, state}, 0);
    chk("rst_outs", {26'd0, data_req, data_wen, rf_we}, 0);
    chk("rst_flags", {30'd0, retire, trap}, 0);
    rst_n = 1'b1;
    alu_step("addiu1", 5'd1, 32'd5, 32'h04);
    alu_step("addiu2", 5'd2, 32'hFFFF_FFFD, 32'h08);
    alu_step("addu", 5'd3, 32'd2, 32'h0C);
    dwait = 3;
    exec();
    chk("sw_cyc", r_cyc, 7);
    chk("sw_we", {31'd0, r_we}, 0);
    chk("sw_dcyc", r_dcyc, 4);
    chk("sw_stable", {31'd0, r_stable}, 1);
    chk("sw_wen", {28'd0, r_wen}, 32'hF);
    chk("sw_addr", {20'd0, r_daddr}, 8);
    chk("sw_wdata", r_dwd, 2);
    chk("sw_mem", dmem[2], 2);
    chk("sw_npc", r_npc, 32'h10);
    exec();
    chk("lw_cyc", r_cyc, 8);
    chk("lw_dcyc", r_dcyc, 4);
    chk("lw_stable", {31'd0, r_stable}, 1);
    chk("lw_wen", {28'd0, r_wen}, 0);
    chk("lw_wa", {27'd0, r_wa}, 4);
    chk("lw_wd", r_wd, 2);
    chk("lw_npc", r_npc, 32'h14);
    dwait = 0;
    exec();
    chk("beq_cyc", r_cyc, 3);
    chk("beq_we", {31'd0, r_we}, 0);
    chk("beq_addr", {20'd0, inst_addr}, 32'h20);
    exec();
    chk("bne_cyc", r_cyc, 3);
    chk("bne_npc", r_npc, 32'h24);
    exec();
    chk("jal_cyc", r_cyc, 3);
    chk("jal_we", {31'd0, r_we}, 1);
    chk("jal_wa", {27'd0, r_wa}, 31);
    chk("jal_wd", r_wd, 32'h24 + 4);
    chk("jal_npc", r_npc, 32'h100);
    exec();
    chk("r0_cyc", r_cyc, 4);
    chk("r0_we", {31'd0, r_we}, 0);
    chk("r0_npc", r_npc, 32'h104);
    alu_step("r0_read", 5'd5, 32'd0, 32'h108);
    alu_step("ra_read", 5'd6, 32'h28, 32'h10C);
    alu_step("subu", 5'd7, 32'hFFFF_FFF8, 32'h110);
    alu_step("slt", 5'd8, 32'd1, 32'h114);
    alu_step("sltu", 5'd9, 32'd0, 32'h118);
    alu_step("sra", 5'd10, 32'hFFFF_FFFE, 32'h11C);
    alu_step("srl", 5'd11, 32'h0000_000F, 32'h120);
    alu_step("andi", 5'd12, 32'h0000_FFF0, 32'h124);
    alu_step("lui", 5'd13, 32'h1234_0000, 32'h128);
    seen_req = 1'b0;
    repeat (5) begin
      seen_req |= data_req;
      tick();
    end
    chk("mis_noreq", {31'd0, seen_req}, 0);
    chk("mis_trap", {31'd0, trap}, 1);
    chk("mis_state", {29'd0, state}, 7);
    chk("mis_pc", pc, 32'h128);
    chk("mis_ireq", {31'd0, inst_req}, 0);
    rst_n = 1'b0;
    #1;
    chk("rst2_state", {29'd0, state}, 0);
    chk("rst2_trap", {31'd0, trap}, 0);
    tick();
    rst_n = 1'b1;
    alu_step("restart", 5'd1, 32'd5, 32'h04);
    inst_en = 1'b0;
    tick();
    tick();
    chk("wait_state", {29'd0, state}, 0);
    chk("wait_req", {31'd0, inst_req}, 1);
    chk("wait_addr", {20'd0, inst_addr}, 32'h04);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, inst_req}, 1);
    chk("midrst_addr", {20'd0, inst_addr}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("hold_state", {29'd0, state}, 0);
    chk("hold_addr", {20'd0, inst_addr}, 0);
    inst_en = 1'b1;
    alu_step("refetch", 5'd1, 32'd5, 32'h04);
    rst_n = 1'b0;
    imem[0] = 32'hFC00_0000;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("undef_trap", {31'd0, trap}, 1);
    chk("undef_state", {29'd0, state}, 7);
    chk("undef_pc", pc, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
